// File: rtl/mac_lane_array.sv
// LANES signed MACs sharing one broadcast image stream; a control FSM runs accumulate, drain and requantise.
// Latency: result valid 6 edges after the last accepted beat. Backpressure: in_ready only in ACC; result held until out_ready.
module mac_lane_array #(
  parameter int LANES   = 4,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int COEFF_W = 17,
  parameter int FRAC_W  = 16,
  parameter int OUT_W   = 8
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  input  logic [15:0]               cfg_len_i,
  input  logic [COEFF_W-1:0]        cfg_coeff_i,
  input  logic                      cfg_relu_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATA_W-1:0]         image_i,
  input  logic [LANES*DATA_W-1:0]   weight_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANES*OUT_W-1:0]    out_data_o,
  output logic                      busy_o
);

  localparam int PRD_W = 2 * DATA_W;
  localparam int PW    = ACC_W + COEFF_W + 1;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC_W - 1);
  localparam logic signed [PW-1:0] OMAX = (PW'(1) << (OUT_W - 1)) - PW'(1);
  localparam logic signed [PW-1:0] OMIN = -OMAX - PW'(1);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_DRAIN, S_QUANT, S_OUT} state_t;

  state_t                     state_q;
  logic [1:0]                 seq_q;
  logic [15:0]                cnt_q;
  logic [15:0]                len_q;
  logic [COEFF_W-1:0]         coeff_q;
  logic                       relu_q;
  logic                       op_vld_q;
  logic                       prod_vld_q;
  logic signed [DATA_W-1:0]   img_q;
  logic signed [DATA_W-1:0]   wgt_q  [LANES];
  logic signed [PRD_W-1:0]    prod_q [LANES];
  logic signed [ACC_W-1:0]    acc_q  [LANES];
  logic signed [PW-1:0]       p1_q   [LANES];
  logic signed [PW-1:0]       p2_q   [LANES];
  logic signed [PW-1:0]       r_q    [LANES];
  logic signed [PW-1:0]       rnd    [LANES];
  logic signed [OUT_W-1:0]    sat    [LANES];
  logic                       accept;

  assign in_ready_o = (state_q == S_ACC);
  assign busy_o     = (state_q != S_IDLE);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    for (int n = 0; n < LANES; n++) begin
      rnd[n] = (p2_q[n] + HALF) >>> FRAC_W;
      if (relu_q && rnd[n][PW-1]) rnd[n] = '0;
      if (r_q[n] > OMAX)      sat[n] = OUT_W'(OMAX);
      else if (r_q[n] < OMIN) sat[n] = OUT_W'(OMIN);
      else                    sat[n] = OUT_W'(r_q[n]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      seq_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      coeff_q     <= '0;
      relu_q      <= 1'b0;
      op_vld_q    <= 1'b0;
      prod_vld_q  <= 1'b0;
      img_q       <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      for (int n = 0; n < LANES; n++) begin
        wgt_q[n]  <= '0;
        prod_q[n] <= '0;
        acc_q[n]  <= '0;
        p1_q[n]   <= '0;
        p2_q[n]   <= '0;
        r_q[n]    <= '0;
      end
    end else begin
      op_vld_q   <= accept;
      prod_vld_q <= op_vld_q;
      if (accept) img_q <= image_i;
      // The requant chain runs freely; the FSM only decides when its output is captured.
      for (int n = 0; n < LANES; n++) begin
        if (accept) wgt_q[n] <= weight_i[n*DATA_W +: DATA_W];
        prod_q[n] <= PRD_W'(img_q) * PRD_W'(wgt_q[n]);
        if (state_q == S_IDLE && start_i) acc_q[n] <= '0;
        else if (prod_vld_q)              acc_q[n] <= acc_q[n] + ACC_W'(prod_q[n]);
        p1_q[n] <= PW'(acc_q[n]) * PW'($signed({1'b0, coeff_q}));
        p2_q[n] <= p1_q[n];
        r_q[n]  <= rnd[n];
      end

      case (state_q)
        S_IDLE: if (start_i) begin
          len_q   <= cfg_len_i;
          coeff_q <= cfg_coeff_i;
          relu_q  <= cfg_relu_i;
          cnt_q   <= '0;
          seq_q   <= '0;
          state_q <= (cfg_len_i != 16'd0) ? S_ACC : S_DRAIN;
        end
        S_ACC: if (accept) begin
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) begin
            seq_q   <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          seq_q <= seq_q + 2'd1;
          if (seq_q == 2'd1) begin
            seq_q   <= '0;
            state_q <= S_QUANT;
          end
        end
        // Four edges: p1, p2 (multiplier retiming), rounded r_q, then saturated capture.
        S_QUANT: begin
          seq_q <= seq_q + 2'd1;
          if (seq_q == 2'd3) begin
            for (int n = 0; n < LANES; n++) out_data_o[n*OUT_W +: OUT_W] <= sat[n];
            out_valid_o <= 1'b1;
            state_q     <= S_OUT;
          end
        end
        S_OUT: if (out_ready_i) begin
          out_valid_o <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_lane_array.sv
// Directed bench for mac_lane_array with two lanes.
module tb_mac_lane_array;

  localparam int LANES = 2;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              start_i = 1'b0;
  logic [15:0]       cfg_len_i = '0;
  logic [16:0]       cfg_coeff_i = '0;
  logic              cfg_relu_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [7:0]        image_i = '0;
  logic [15:0]       weight_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [15:0]       out_data_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;
  logic signed [7:0] img_v [8];
  logic signed [7:0] w0_v  [8];
  logic signed [7:0] w1_v  [8];
  logic [15:0]       held;

  mac_lane_array #(.LANES(LANES)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .cfg_len_i(cfg_len_i),
    .cfg_coeff_i(cfg_coeff_i), .cfg_relu_i(cfg_relu_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .image_i(image_i), .weight_i(weight_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e0, input int e1);
    chk({tag, "_lane0"}, 64'($signed(out_data_o[7:0])), 64'(e0));
    chk({tag, "_lane1"}, 64'($signed(out_data_o[15:8])), 64'(e1));
  endtask

  // Starts a job, feeds len beats from the vector tables, waits for the result.
  task automatic run_job(input string tag, input int len, input int coeff, input bit relu, input bit stall);
    int n;
    cfg_len_i   = 16'(len);
    cfg_coeff_i = 17'(coeff);
    cfg_relu_i  = relu;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (stall) begin
        in_valid_i = 1'b0;
        tick();
      end
      image_i    = img_v[i];
      weight_i   = {w1_v[i], w0_v[i]};
      in_valid_i = 1'b1;
      if (i == 0) chk({tag, "_in_ready"}, 64'(in_ready_o), 64'(1));
      tick();
      in_valid_i = 1'b0;
    end
    n = 0;
    while (out_valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(6));
  endtask

  task automatic release_out(input string tag);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk({tag, "_valid_clr"}, 64'(out_valid_o), 64'(0));
    chk({tag, "_idle"}, 64'(busy_o), 64'(0));
  endtask

  initial begin
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready_o), 64'(0));
    chk("rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("rst_out_data", 64'(out_data_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    rstn_i = 1'b1;
    tick();

    img_v[0] = 1;  img_v[1] = 2;  img_v[2] = 3;
    w0_v[0]  = 4;  w0_v[1]  = 5;  w0_v[2]  = 6;
    w1_v[0]  = -10; w1_v[1] = -10; w1_v[2] = -10;
    run_job("basic", 3, 65536, 1'b0, 1'b0);
    chk_out("basic", 32, -60);
    release_out("basic");

    run_job("relu", 3, 65536, 1'b1, 1'b0);
    chk_out("relu", 32, 0);
    release_out("relu");

    for (int i = 0; i < 4; i++) begin
      img_v[i] = 127; w0_v[i] = 127; w1_v[i] = -128;
    end
    run_job("sat", 4, 65536, 1'b0, 1'b0);
    chk_out("sat", 127, -128);
    release_out("sat");

    img_v[0] = 3; w0_v[0] = 1; w1_v[0] = -1;
    run_job("round", 1, 32768, 1'b0, 1'b0);
    chk_out("round", 2, -1);
    release_out("round");

    img_v[0] = 1; img_v[1] = 2; img_v[2] = 3; img_v[3] = 4;
    w0_v[0]  = 1; w0_v[1]  = 1; w0_v[2]  = 1; w0_v[3]  = 1;
    w1_v[0]  = 2; w1_v[1]  = -3; w1_v[2] = 0; w1_v[3]  = -1;
    run_job("nostall", 4, 65536, 1'b0, 1'b0);
    chk_out("nostall", 10, -8);
    release_out("nostall");
    run_job("stall", 4, 65536, 1'b0, 1'b1);
    chk_out("stall", 10, -8);

    // Hold the result with out_ready low while start pulses arrive.
    held = out_data_o;
    for (int i = 0; i < 10; i++) begin
      start_i = (i % 2 == 0);
      tick();
      chk("hold_valid", 64'(out_valid_o), 64'(1));
      chk("hold_data", 64'(out_data_o), 64'(held));
      chk("hold_in_ready", 64'(in_ready_o), 64'(0));
    end
    // A start coinciding with the output handshake is ignored.
    start_i     = 1'b1;
    cfg_len_i   = 16'd1;
    out_ready_i = 1'b1;
    tick();
    start_i     = 1'b0;
    out_ready_i = 1'b0;
    chk("hs_start_valid", 64'(out_valid_o), 64'(0));
    chk("hs_start_busy", 64'(busy_o), 64'(0));
    chk("hs_data_kept", 64'(out_data_o), 64'(held));
    tick();
    chk("hs_still_idle", 64'(busy_o), 64'(0));

    run_job("zero_len", 0, 65536, 1'b0, 1'b0);
    chk_out("zero_len", 0, 0);
    release_out("zero_len");

    // Abort a 5-beat job after two beats.
    for (int i = 0; i < 2; i++) begin
      img_v[i] = 50; w0_v[i] = 50; w1_v[i] = -50;
    end
    cfg_len_i   = 16'd5;
    cfg_coeff_i = 17'd65536;
    cfg_relu_i  = 1'b0;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      image_i    = img_v[i];
      weight_i   = {w1_v[i], w0_v[i]};
      in_valid_i = 1'b1;
      tick();
    end
    in_valid_i = 1'b0;
    rstn_i = 1'b0;
    tick();
    chk("abort_in_ready", 64'(in_ready_o), 64'(0));
    chk("abort_busy", 64'(busy_o), 64'(0));
    chk("abort_out_valid", 64'(out_valid_o), 64'(0));
    rstn_i = 1'b1;
    tick();

    img_v[0] = 2; w0_v[0] = 3; w1_v[0] = -4;
    run_job("fresh", 1, 65536, 1'b0, 1'b0);
    chk_out("fresh", 6, -8);
    release_out("fresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
